ps2_keyboard_rx: RTL
====================

# ps2_keyboard_rx

Receives serial frames from a PS/2 keyboard and delivers complete scan-code bytes with a one-cycle valid strobe. Sits directly upstream of `ps2_lcd_interface`, driving its `ps2_code` and `ps2_code_new` inputs. Synchronises and filters the keyboard's open-collector lines, checks frame integrity, and aborts stalled frames. Optionally strips break (`F0 xx`) and extended (`E0`) prefixes so each keypress produces exactly one strobe.

## Interface
- `FILTER_LEN`, 8: consecutive identical system-clock samples required before a filtered line changes (1..255).
- `TIMEOUT_CYCLES`, 50000: idle clocks allowed between falling edges mid-frame before abort (1 ms at 50 MHz).
- `SUPPRESS_BREAK`, 1: 1 = consume `F0`, its following byte, and `E0` without strobing. 0 = strobe every byte.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `ps2_clk` in 1: keyboard clock, asynchronous.
- `ps2_data` in 1: keyboard data, asynchronous.
- `ps2_code` out 8: last delivered byte, held until the next delivery.
- `ps2_code_new` out 1: one-cycle pulse; `ps2_code` is valid in the same cycle.
- `frame_err` out 1: one-cycle pulse on a bad start, parity, or stop bit, or on timeout.
- `busy` out 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Each input passes through a 2-FF synchroniser, then a glitch filter. The filtered value follows the raw value only after `FILTER_LEN` equal consecutive samples. The filter resets to 1 (idle-high bus).
- Falling edge: filtered `ps2_clk` was 1 in the previous cycle and is 0 in the current one. Data is sampled from filtered `ps2_data` in the edge cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a falling edge with data = 0, go to DATA and clear the bit count. On a falling edge with data = 1, pulse `frame_err` and stay in IDLE.
  - DATA: shift the sampled bit into the shift register LSB-first. After the 8th bit (count 7), go to PARITY.
  - PARITY: latch the sampled bit, go to STOP. Parity is good when the XOR of the 8 data bits and the parity bit is 1 (odd parity).
  - STOP: on the falling edge, go to IDLE. If stop = 1 and parity is good, the frame is valid. Otherwise pulse `frame_err`.
- Valid-byte handling when `SUPPRESS_BREAK` = 1:
  - `8'hF0`: set `brk_pend`, no strobe.
  - `8'hE0`: no strobe, `brk_pend` unchanged.
  - Other byte with `brk_pend` = 1: clear `brk_pend`, no strobe.
  - Otherwise: load `ps2_code` and pulse `ps2_code_new`.
- When `SUPPRESS_BREAK` = 0, every valid byte is delivered.
- Timeout counter: clears on every falling edge and while in IDLE, and increments otherwise (saturating). Reaching `TIMEOUT_CYCLES` outside IDLE forces IDLE and pulses `frame_err`. `brk_pend` is cleared on timeout and on any frame error.
- An invalid frame never modifies `ps2_code`.

## Timing
- Reset values: `ps2_code` = 0, `ps2_code_new` = 0, `frame_err` = 0, `busy` = 0, FSM = IDLE, `brk_pend` = 0, filters = 1, counters = 0.
- Pin-to-edge latency is 2 (synchroniser) + `FILTER_LEN` cycles.
- `ps2_code_new` asserts in the cycle after the stop-bit falling-edge cycle, for exactly one cycle. `ps2_code` updates in that same cycle.
- `ps2_code_new` and `frame_err` are never high in the same cycle.
- `rst` low mid-frame returns every register to its reset value on the next rising edge. No strobe is produced for the partial frame.
- A timeout and a falling edge in the same cycle: the edge wins and the counter clears.

## Structure
- Package `ps2_pkg`:
  - `ps2_state_t` enum {IDLE, DATA, PARITY, STOP}.
  - Constants `PS2_BREAK` = 8'hF0 and `PS2_EXT` = 8'hE0.
- Sub-module `ps2_line_filter` (synchroniser plus glitch filter, parameter `FILTER_LEN`), instantiated once for `ps2_clk` and once for `ps2_data`.

## Test plan
- Make code: frame for 8'h1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) -> `ps2_code` = 8'h1C, one `ps2_code_new` pulse, `frame_err` stays low.
- Break sequence: frames F0 then 1C with `SUPPRESS_BREAK` = 1 -> no strobe, `ps2_code` unchanged. Repeat with `SUPPRESS_BREAK` = 0 -> two strobes (F0, then 1C).
- Bad parity: 8'h1C sent with parity 1 -> `frame_err` pulse, no strobe. A following good 8'h32 frame -> strobe with 8'h32.
- Stall: start bit plus 3 data bits, then `ps2_clk` held high for `TIMEOUT_CYCLES` -> `frame_err` pulse, `busy` low. A following complete 8'h24 frame -> strobe.
- Glitch: 3-cycle low pulse on `ps2_clk` with `FILTER_LEN` = 8 -> no state change, `busy` stays low.
- Reset mid-frame: `rst` low after 5 data bits -> all outputs return to their reset values. A later full 8'h1C frame -> normal strobe.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Covers the frame FSM state encoding, the prefix byte values and the parity rule.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a glitch filter for one open-collector PS/2 line.
// The filtered output changes only after FILTER_LEN consecutive equal samples of the new level.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q, sync_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter tracks how long the synchronised level has disagreed with the output.
  always_comb begin
    sync_d = {sync_q[0], raw};
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard frame receiver: filters the lines, decodes 11-bit frames, aborts stalls,
// and optionally swallows break/extended prefixes so each keypress strobes once.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit SUPPRESS_BREAK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_code,
  output logic       ps2_code_new,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  logic clk_filt, data_filt;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk  (clk),
    .rst  (rst),
    .raw  (ps2_clk),
    .filt (clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk  (clk),
    .rst  (rst),
    .raw  (ps2_data),
    .filt (data_filt)
  );

  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          brk_pend_q, brk_pend_d;
  logic [7:0]    code_q, code_d;
  logic          code_new_q, code_new_d;
  logic          frame_err_q, frame_err_d;
  logic          clk_prev_q;
  logic          fall;

  assign fall = clk_prev_q & ~clk_filt;

  // A falling edge always takes priority over the stall timeout, so a late edge still counts.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tmo_cnt_d   = tmo_cnt_q;
    brk_pend_d  = brk_pend_q;
    code_d      = code_q;
    code_new_d  = 1'b0;
    frame_err_d = 1'b0;

    if (fall) begin
      tmo_cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!data_filt) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
            brk_pend_d  = 1'b0;
          end
        end
        DATA: begin
          shift_d   = {data_filt, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_d = data_filt;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_filt && odd_parity_ok(shift_q, parity_q)) begin
            if (!SUPPRESS_BREAK) begin
              code_d     = shift_q;
              code_new_d = 1'b1;
            end else if (shift_q == PS2_BREAK) begin
              brk_pend_d = 1'b1;
            end else if (shift_q == PS2_EXT) begin
              brk_pend_d = brk_pend_q;
            end else if (brk_pend_q) begin
              brk_pend_d = 1'b0;
            end else begin
              code_d     = shift_q;
              code_new_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            brk_pend_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q >= TMO_LIMIT) begin
      state_d     = IDLE;
      tmo_cnt_d   = '0;
      frame_err_d = 1'b1;
      brk_pend_d  = 1'b0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      brk_pend_q  <= 1'b0;
      code_q      <= '0;
      code_new_q  <= 1'b0;
      frame_err_q <= 1'b0;
      clk_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_cnt_q   <= tmo_cnt_d;
      brk_pend_q  <= brk_pend_d;
      code_q      <= code_d;
      code_new_q  <= code_new_d;
      frame_err_q <= frame_err_d;
      clk_prev_q  <= clk_filt;
    end
  end

  assign ps2_code     = code_q;
  assign ps2_code_new = code_new_q;
  assign frame_err    = frame_err_q;
  assign busy         = (state_q != IDLE);

endmodule
